change_dispenser: RTL and testbench

- Downstream stage of the vending `fsm`. Consumes its `vend` and `change[2:0]` outputs.
- Releases the drink, then returns change as physical coins through a dime ejector and a nickel ejector. Each ejection uses an acknowledge handshake.
- Tracks on-board nickel and dime stock, and flags short change and ejector faults.

---
 rtl/change_dispenser_if.sv | 41 ++++
 rtl/change_dispenser.sv | 181 ++++++++++++++++++
 tb/tb_change_dispenser.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : change_dispenser_if
// Purpose  : Request / coin-ejector / status bundle between the vending
//            controller side (master) and the change dispenser (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface change_dispenser_if #(
  parameter int STOCK_W = 6
);
  logic               vend;
  logic [2:0]         change;
  logic               refill;
  logic               eject_ack;
  logic               eject_nickel;
  logic               eject_dime;
  logic               drink_release;
  logic               busy;
  logic               dispense_done;
  logic               short_change;
  logic               eject_fault;
  logic               overrun;
  logic [STOCK_W-1:0] nickel_cnt;
  logic [STOCK_W-1:0] dime_cnt;

  // Controller side: issues requests and answers on behalf of the ejectors
  modport master (
    output vend, change, refill, eject_ack,
    input  eject_nickel, eject_dime, drink_release, busy, dispense_done,
           short_change, eject_fault, overrun, nickel_cnt, dime_cnt
  );

  // Dispenser side
  modport slave (
    input  vend, change, refill, eject_ack,
    output eject_nickel, eject_dime, drink_release, busy, dispense_done,
           short_change, eject_fault, overrun, nickel_cnt, dime_cnt
  );
endinterface
`default_nettype wire

// File: rtl/change_dispenser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Releases the drink, then pays out change owed (in nickels) as
//            dimes and nickels through two acknowledged coin ejectors while
//            tracking on-board coin stock and flagging short change / faults.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
  parameter int NICKEL_INIT  = 20,
  parameter int DIME_INIT    = 20,
  parameter int STOCK_W      = 6,
  parameter int DRINK_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int ACK_TIMEOUT  = 8
) (
  input  wire logic          clock,
  input  wire logic          reset,
  change_dispenser_if.slave  bus
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_DRINK  = 3'd1;
  localparam logic [2:0] c_SELECT = 3'd2;
  localparam logic [2:0] c_EJECT  = 3'd3;
  localparam logic [2:0] c_GAP    = 3'd4;
  localparam logic [2:0] c_DONE   = 3'd5;

  // One shared timer serves the drink, ejection-timeout and gap phases
  localparam int c_TMAX_A  = (DRINK_CYCLES > GAP_CYCLES) ? DRINK_CYCLES : GAP_CYCLES;
  localparam int c_TMAX    = (c_TMAX_A > ACK_TIMEOUT) ? c_TMAX_A : ACK_TIMEOUT;
  localparam int c_TIMER_W = (c_TMAX < 2) ? 1 : $clog2(c_TMAX + 1);

  localparam logic [c_TIMER_W-1:0] c_DRINK_LAST = c_TIMER_W'(DRINK_CYCLES - 1);
  localparam logic [c_TIMER_W-1:0] c_GAP_LAST   = c_TIMER_W'(GAP_CYCLES - 1);
  localparam logic [c_TIMER_W-1:0] c_ACK_LAST   = c_TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [c_TIMER_W-1:0] c_TIMER_ONE  = c_TIMER_W'(1);
  localparam logic [STOCK_W-1:0]   c_NICKEL_INI = STOCK_W'(NICKEL_INIT);
  localparam logic [STOCK_W-1:0]   c_DIME_INI   = STOCK_W'(DIME_INIT);
  localparam logic [STOCK_W-1:0]   c_STOCK_ONE  = STOCK_W'(1);

  logic [2:0]           r_state;
  logic [c_TIMER_W-1:0] r_timer;
  logic [2:0]           r_owed;
  logic                 r_drink_flag;
  logic                 r_invalid;
  logic                 r_coin_dime;
  logic                 r_short;
  logic                 r_fault;
  logic                 r_overrun;
  logic [STOCK_W-1:0]   r_nickel;
  logic [STOCK_W-1:0]   r_dime;

  logic w_trigger;
  logic w_idle;
  logic w_bad_code;

  assign w_trigger  = bus.vend | (bus.change != 3'd0);
  assign w_idle     = (r_state == c_IDLE);
  assign w_bad_code = (bus.change > 3'd5);

  // Sequencer: accepts a request in IDLE, then drink -> (select/eject/gap)* -> done
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= c_IDLE;
      r_timer      <= '0;
      r_owed       <= 3'd0;
      r_drink_flag <= 1'b0;
      r_invalid    <= 1'b0;
      r_coin_dime  <= 1'b0;
      r_short      <= 1'b0;
      r_fault      <= 1'b0;
      r_overrun    <= 1'b0;
      r_nickel     <= c_NICKEL_INI;
      r_dime       <= c_DIME_INI;
    end else begin
      case (r_state)
        c_IDLE: begin
          // Refill lands on the same edge as a trigger, so the new stock is used
          if (bus.refill) begin
            r_nickel <= c_NICKEL_INI;
            r_dime   <= c_DIME_INI;
          end
          if (w_trigger) begin
            r_drink_flag <= bus.vend;
            r_invalid    <= w_bad_code;
            r_owed       <= w_bad_code ? 3'd0 : bus.change;
            r_short      <= 1'b0;
            r_fault      <= 1'b0;
            r_overrun    <= 1'b0;
            r_timer      <= '0;
            r_state      <= c_DRINK;
          end
        end

        c_DRINK: begin
          if (!r_drink_flag || (r_timer == c_DRINK_LAST)) begin
            r_state <= c_SELECT;
          end else begin
            r_timer <= r_timer + c_TIMER_ONE;
          end
        end

        c_SELECT: begin
          r_timer <= '0;
          if (r_owed == 3'd0) begin
            r_short <= r_invalid;
            r_state <= c_DONE;
          end else if ((r_owed >= 3'd2) && (r_dime != '0)) begin
            r_coin_dime <= 1'b1;
            r_state     <= c_EJECT;
          end else if (r_nickel != '0) begin
            r_coin_dime <= 1'b0;
            r_state     <= c_EJECT;
          end else begin
            // Change still owed but no usable coin left
            r_short <= 1'b1;
            r_state <= c_DONE;
          end
        end

        c_EJECT: begin
          if (bus.eject_ack) begin
            if (r_coin_dime) begin
              r_owed <= r_owed - 3'd2;
              r_dime <= r_dime - c_STOCK_ONE;
            end else begin
              r_owed   <= r_owed - 3'd1;
              r_nickel <= r_nickel - c_STOCK_ONE;
            end
            r_timer <= '0;
            r_state <= c_GAP;
          end else if (r_timer == c_ACK_LAST) begin
            // A coin was being paid, so change is necessarily still owed
            r_fault <= 1'b1;
            r_short <= 1'b1;
            r_state <= c_DONE;
          end else begin
            r_timer <= r_timer + c_TIMER_ONE;
          end
        end

        c_GAP: begin
          if (r_timer == c_GAP_LAST) begin
            r_state <= c_SELECT;
          end else begin
            r_timer <= r_timer + c_TIMER_ONE;
          end
        end

        c_DONE: begin
          r_state <= c_IDLE;
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase

      // A request presented while busy is dropped but remembered
      if (!w_idle && w_trigger) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Drives decode straight from state so reset removes them without a clock
  assign bus.eject_nickel  = (r_state == c_EJECT) & ~r_coin_dime;
  assign bus.eject_dime    = (r_state == c_EJECT) &  r_coin_dime;
  assign bus.drink_release = (r_state == c_DRINK) &  r_drink_flag;
  assign bus.busy          = ~w_idle;
  assign bus.dispense_done = (r_state == c_DONE);
  assign bus.short_change  = r_short;
  assign bus.eject_fault   = r_fault;
  assign bus.overrun       = r_overrun;
  assign bus.nickel_cnt    = r_nickel;
  assign bus.dime_cnt      = r_dime;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Self-checking bench for change_dispenser: fixed vector table,
//            hand-written corner sequences and random requests against a
//            greedy-payout reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

  localparam int NEVER   = 1000;
  localparam int INIT_N  = 20;
  localparam int INIT_D  = 20;
  localparam int DRINK_N = 4;
  localparam int ACK_TO  = 8;
  localparam int GAP_N   = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  change_dispenser_if #(.STOCK_W(6)) bus();

  change_dispenser #(
    .NICKEL_INIT(INIT_N), .DIME_INIT(INIT_D), .STOCK_W(6),
    .DRINK_CYCLES(DRINK_N), .GAP_CYCLES(GAP_N), .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model stock
  int m_nick, m_dime;
  // model expectations
  int e_drink, e_n, e_done, e_req;
  logic [7:0] e_coins;
  bit e_sc, e_ef;
  // observations
  int o_drink, o_n, o_done_cyc, o_req, o_nick, o_dime;
  logic [7:0] o_coins;
  bit o_done, o_sc, o_ef, o_both, o_busy0, o_ovr;

  typedef struct {
    bit v; logic [2:0] ch; bit rf; int a;
    int x_drink; int x_n; logic [7:0] x_coins; bit x_sc; bit x_ef; int x_nick; int x_dime;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Greedy payout from the rules: dimes while >=2 owed and in stock, else nickels
  task automatic model(input bit v, input logic [2:0] ch, input bit rf, input int a);
    int owed, d;
    bit inv, dime;
    if (rf) begin m_nick = INIT_N; m_dime = INIT_D; end
    inv = (ch > 3'd5);
    owed = inv ? 0 : int'(ch);
    e_drink = v ? DRINK_N : 0;
    d = v ? DRINK_N : 1;
    e_n = 0; e_coins = '0; e_ef = 0; e_req = 0;
    while (owed > 0) begin
      if (owed >= 2 && m_dime > 0) dime = 1;
      else if (m_nick > 0) dime = 0;
      else break;
      e_coins[e_n] = dime;
      e_n++;
      if (a >= NEVER) begin e_ef = 1; e_req += ACK_TO; break; end
      e_req += a + 1;
      if (dime) begin owed -= 2; m_dime--; end
      else begin owed -= 1; m_nick--; end
    end
    e_sc = inv || (owed != 0);
    e_done = e_ef ? d + 1 + ACK_TO : d + e_n * (a + 2 + GAP_N) + 1;
  endtask

  // Presents one request, plays the ejectors (ack after 'a' cycles), observes to done
  task automatic run_txn(input bit v, input logic [2:0] ch, input bit rf, input int a);
    bit req, prev;
    int cd;
    o_drink = 0; o_n = 0; o_coins = '0; o_req = 0; o_done = 0; o_done_cyc = -1;
    o_sc = 0; o_ef = 0; o_both = 0; o_ovr = 1; o_nick = -1; o_dime = -1;
    prev = 0; cd = 0;
    @(negedge clock);
    bus.vend = v; bus.change = ch; bus.refill = rf;
    @(negedge clock);
    bus.vend = 0; bus.change = 3'd0; bus.refill = 0;
    o_busy0 = bus.busy;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge clock);
      bus.eject_ack = 0;
      if (bus.drink_release) o_drink++;
      if (bus.eject_nickel && bus.eject_dime) o_both = 1;
      req = bus.eject_nickel | bus.eject_dime;
      if (req) o_req++;
      if (req && !prev) begin
        if (o_n < 8) o_coins[o_n] = bus.eject_dime;
        o_n++;
        cd = a;
      end
      if (req) begin
        if (cd == 0) bus.eject_ack = 1;
        else cd--;
      end
      prev = req;
      if (bus.dispense_done) begin
        o_done = 1; o_done_cyc = cyc;
        o_sc = bus.short_change; o_ef = bus.eject_fault; o_ovr = bus.overrun;
        o_nick = int'(bus.nickel_cnt); o_dime = int'(bus.dime_cnt);
        break;
      end
    end
    bus.eject_ack = 0;
    @(negedge clock);
  endtask

  // Run one request and compare everything against the model
  task automatic txn(input string nm, input bit v, input logic [2:0] ch, input bit rf, input int a);
    run_txn(v, ch, rf, a);
    model(v, ch, rf, a);
    check({nm, ".busy"},    o_busy0, 1);
    check({nm, ".done"},    o_done, 1);
    check({nm, ".latency"}, o_done_cyc, e_done);
    check({nm, ".drink"},   o_drink, e_drink);
    check({nm, ".ncoins"},  o_n, e_n);
    check({nm, ".coins"},   o_coins, e_coins);
    check({nm, ".reqcyc"},  o_req, e_req);
    check({nm, ".short"},   o_sc, e_sc);
    check({nm, ".fault"},   o_ef, e_ef);
    check({nm, ".ovr"},     o_ovr, 0);
    check({nm, ".onehot"},  o_both, 0);
    check({nm, ".nick"},    o_nick, m_nick);
    check({nm, ".dime"},    o_dime, m_dime);
    check({nm, ".idle"},    bus.busy, 0);
  endtask

  initial begin
    bit seen, ej;
    bit rv, rr;
    logic [2:0] rc;
    int ra;

    //           v  ch    rf a      drink n coins  sc ef nick dime
    tbl[0] = '{1, 3'd0, 0, 0,     4, 0, 8'b000, 0, 0, 20, 20};
    tbl[1] = '{1, 3'd5, 0, 0,     4, 3, 8'b011, 0, 0, 19, 18};
    tbl[2] = '{0, 3'd2, 0, NEVER, 0, 1, 8'b001, 1, 1, 19, 18};
    tbl[3] = '{0, 3'd6, 0, 0,     0, 0, 8'b000, 1, 0, 19, 18};
    tbl[4] = '{1, 3'd1, 0, 2,     4, 1, 8'b000, 0, 0, 18, 18};
    tbl[5] = '{0, 3'd3, 1, 1,     0, 2, 8'b001, 0, 0, 19, 19};
    tbl[6] = '{1, 3'd7, 0, 0,     4, 0, 8'b000, 1, 0, 19, 19};
    tbl[7] = '{0, 3'd4, 0, 3,     0, 2, 8'b011, 0, 0, 19, 17};

    bus.vend = 0; bus.change = 3'd0; bus.refill = 0; bus.eject_ack = 0;
    m_nick = INIT_N; m_dime = INIT_D;

    // reset state
    repeat (3) @(negedge clock);
    check("rst.busy",  bus.busy, 0);
    check("rst.eject", {bus.eject_nickel, bus.eject_dime}, 0);
    check("rst.drink", bus.drink_release, 0);
    check("rst.flags", {bus.dispense_done, bus.short_change, bus.eject_fault, bus.overrun}, 0);
    check("rst.nick",  bus.nickel_cnt, INIT_N);
    check("rst.dime",  bus.dime_cnt, INIT_D);
    reset = 1'b1;

    // fixed vectors
    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("tbl%0d", i);
      txn(nm, tbl[i].v, tbl[i].ch, tbl[i].rf, tbl[i].a);
      check({nm, ".t_drink"}, o_drink, tbl[i].x_drink);
      check({nm, ".t_n"},     o_n, tbl[i].x_n);
      check({nm, ".t_coins"}, o_coins, tbl[i].x_coins);
      check({nm, ".t_sc"},    o_sc, tbl[i].x_sc);
      check({nm, ".t_ef"},    o_ef, tbl[i].x_ef);
      check({nm, ".t_nick"},  o_nick, tbl[i].x_nick);
      check({nm, ".t_dime"},  o_dime, tbl[i].x_dime);
    end

    // reset asserted mid-EJECT (stock is 19/17 here)
    @(negedge clock); bus.change = 3'd2;
    @(negedge clock); bus.change = 3'd0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (bus.eject_dime) seen = 1;
    end
    check("mid.ejecting", seen, 1);
    #2 reset = 1'b0;
    #1;
    check("mid.eject", {bus.eject_nickel, bus.eject_dime}, 0);
    check("mid.busy",  bus.busy, 0);
    check("mid.drink", bus.drink_release, 0);
    check("mid.nick",  bus.nickel_cnt, INIT_N);
    check("mid.dime",  bus.dime_cnt, INIT_D);
    @(negedge clock); reset = 1'b1;
    m_nick = INIT_N; m_dime = INIT_D;

    // drain dimes, then change of 15c must come out as three nickels
    for (int i = 0; i < 10; i++) txn($sformatf("drain_d%0d", i), 0, 3'd4, 0, 0);
    txn("nnn", 1, 3'd3, 0, 1);
    check("nnn.n",     o_n, 3);
    check("nnn.coins", o_coins, 8'b000);
    check("nnn.nick",  o_nick, 17);
    check("nnn.dime",  o_dime, 0);

    // refill then drain nickels; 5c with only dimes left is short change
    txn("drain_n0", 0, 3'd1, 1, 0);
    for (int i = 1; i < 20; i++) txn($sformatf("drain_n%0d", i), 0, 3'd1, 0, 0);
    txn("noN", 0, 3'd1, 0, 0);
    check("noN.n",    o_n, 0);
    check("noN.sc",   o_sc, 1);
    check("noN.done", o_done, 1);
    check("noN.nick", o_nick, 0);
    check("noN.dime", o_dime, 20);

    // second request during DRINK is dropped and flagged
    @(negedge clock); bus.vend = 1;
    @(negedge clock); bus.vend = 0;
    @(negedge clock); bus.vend = 1; bus.change = 3'd2;
    @(negedge clock); bus.vend = 0; bus.change = 3'd0;
    seen = 0; ej = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.eject_nickel || bus.eject_dime) ej = 1;
      if (bus.dispense_done) begin
        seen = 1;
        check("ovr.flag",  bus.overrun, 1);
        check("ovr.sc",    bus.short_change, 0);
        check("ovr.dime",  bus.dime_cnt, 20);
      end else @(negedge clock);
    end
    check("ovr.done",  seen, 1);
    check("ovr.noej",  ej, 0);
    @(negedge clock);
    check("ovr.idle",   bus.busy, 0);
    check("ovr.sticky", bus.overrun, 1);
    txn("ovr.clear", 1, 3'd0, 0, 0);

    // random requests against the model
    for (int i = 0; i < 40; i++) begin
      rv = 1'($urandom_range(0, 1));
      rc = 3'($urandom_range(0, 7));
      if (!rv && rc == 3'd0) rv = 1;
      rr = ($urandom_range(0, 5) == 0);
      ra = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 4));
      txn($sformatf("rnd%0d", i), rv, rc, rr, ra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case a wait ever runs away
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
